jtag_uart_bridge: RTL and testbench
===================================

JTAG_UART_BRIDGE -- requirements
Module: jtag_uart_bridge

Interface
REQ-001 SHALL have parameter DR_LENGTH, default 32, giving the virtual-JTAG data register width (minimum 16).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port jtag_tx_in, input, DR_LENGTH, the TCK-domain host-to-CPU word. Bit [DR_LENGTH-1] is the send toggle, bit [DR_LENGTH-2] is clear-overflow, bits [7:0] are the data byte.
REQ-005 SHALL have port jtag_rx_ack, input, 1, the TCK-domain host toggle acknowledging the byte it has read.
REQ-006 SHALL have port uart_state, output, DR_LENGTH, status word read by the host over JTAG.
REQ-007 SHALL have ports cpu_rx_data (output, 8), cpu_rx_valid (output, 1) and cpu_rx_ready (input, 1), forming the host-to-CPU byte stream.
REQ-008 SHALL have ports cpu_tx_data (input, 8), cpu_tx_valid (input, 1) and cpu_tx_ready (output, 1), forming the CPU-to-host byte stream.
REQ-009 SHALL have port overflow, output, 1, a sticky flag set when a host byte is dropped.

Function
REQ-010 SHALL synchronise jtag_tx_in[DR_LENGTH-1] and jtag_rx_ack through two flops each; no other jtag_tx_in bit is synchronised.
REQ-011 SHALL detect a host event when the synchronised send toggle differs from the registered value seen_tgl. On that cycle it samples jtag_tx_in[DR_LENGTH-2] and jtag_tx_in[7:0] directly and sets seen_tgl to the synchronised toggle. The host holds the data stable for at least 3 clk before it flips the toggle.
REQ-012 SHALL, on a host event with clear-overflow=1, clear overflow and push nothing.
REQ-013 SHALL, on a host event with clear-overflow=0, push the byte into an 8-entry FIFO when count<8 or when a pop occurs in the same cycle; otherwise it drops the byte and sets overflow.
REQ-014 SHALL implement the FIFO with 3-bit wptr/rptr wrapping 7->0 and a 4-bit count in the range 0..8.
- Push alone: count+1.
- Pop alone: count-1.
- Push and pop together: count unchanged.
REQ-015 SHALL drive cpu_rx_valid = (count!=0) and cpu_rx_data = mem[rptr] (first-word fall-through). A pop occurs when cpu_rx_valid & cpu_rx_ready, and cpu_rx_data and cpu_rx_valid are unspecified-free when count==0 (data may be stale; valid is 0).
REQ-016 SHALL make a pushed byte visible on cpu_rx_valid/cpu_rx_data the cycle after the push; end-to-end latency from the TCK-side toggle flip is at most 4 clk.
REQ-017 SHALL run the CPU-to-host FSM with states IDLE and WAIT_ACK.
- IDLE: cpu_tx_ready=1. On cpu_tx_valid it latches cpu_tx_data into host_byte, inverts host_tgl and goes to WAIT_ACK.
- WAIT_ACK: cpu_tx_ready=0. It returns to IDLE on the first cycle the synchronised jtag_rx_ack equals host_tgl.
REQ-018 SHALL register uart_state every cycle as follows:
- [7:0] = host_byte
- [8] = host_tgl
- [12:9] = count
- [13] = overflow
- [14] = seen_tgl
- [15] = (state==WAIT_ACK)
- all higher bits 0
REQ-019 SHALL not combinationally depend on cpu_tx_valid when driving cpu_tx_ready; ready is a decode of the registered state only.

Reset
REQ-020 SHALL, on reset_n low, asynchronously clear to 0 all synchroniser flops, seen_tgl, host_tgl, host_byte, wptr, rptr, count, overflow and uart_state, and set state=IDLE.
- Outputs during reset: cpu_rx_valid=0, cpu_tx_ready=1, overflow=0, uart_state=0.
REQ-021 SHALL leave FIFO memory contents unreset; they are unobservable while count==0.
REQ-022 SHALL, on reset asserted mid-transfer (e.g. in WAIT_ACK or with count>0), discard all pending data. After release the host resynchronises by reading uart_state[14] and uart_state[8].

Verification
REQ-023 SHALL pass: host sends 0x41 (toggle 0->1), cpu_rx_ready=1 -> cpu_rx_valid pulses one cycle with 0x41 within 4 clk; uart_state[14]=1; count returns to 0.
REQ-024 SHALL pass: 9 host bytes 0x00..0x08 with cpu_rx_ready=0 -> count=8; overflow=1 after the ninth; draining yields 0x00..0x07 in order; a clear-overflow event then sets overflow=0 and count stays 0.
REQ-025 SHALL pass: FIFO full, and in one cycle a host event plus cpu_rx_ready=1 -> byte accepted, count stays 8, overflow stays 0.
REQ-026 SHALL pass: CPU sends 0x5A -> next cycle uart_state[7:0]=0x5A, [8]=1, [15]=1, cpu_tx_ready=0; host flips jtag_rx_ack to 1 -> IDLE within 3 clk, cpu_tx_ready=1.
REQ-027 SHALL pass: reset_n pulsed low while in WAIT_ACK with count=3 -> immediately uart_state=0, cpu_rx_valid=0, cpu_tx_ready=1; no byte is emitted after release.
REQ-028 SHALL pass: 20 consecutive bytes with the FIFO kept drained -> wptr/rptr wrap twice; all 20 delivered in order with no overflow.

Source files
------------

// File: rtl/jtag_uart_bridge.sv
// Byte-wide bridge between a virtual-JTAG data register (TCK domain) and a
// CPU-side valid/ready byte stream, with an 8-entry host-to-CPU FIFO.
module jtag_uart_bridge #(
  parameter int DR_LENGTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DR_LENGTH-1:0] jtag_tx_in,
  input  logic                 jtag_rx_ack,
  output logic [DR_LENGTH-1:0] uart_state,
  output logic [7:0]           cpu_rx_data,
  output logic                 cpu_rx_valid,
  input  logic                 cpu_rx_ready,
  input  logic [7:0]           cpu_tx_data,
  input  logic                 cpu_tx_valid,
  output logic                 cpu_tx_ready,
  output logic                 overflow
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } tx_state_e;

  logic                 tx_tgl_meta_q, tx_tgl_sync_q;
  logic                 ack_meta_q, ack_sync_q;
  logic                 seen_tgl_q;
  logic [2:0]           wptr_q, rptr_q;
  logic [3:0]           count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           mem_q [8];
  tx_state_e            state_q;
  logic                 host_tgl_q;
  logic [7:0]           host_byte_q;
  logic                 tx_ready_q;
  logic [DR_LENGTH-1:0] uart_state_q, uart_state_d;
  logic                 host_evt_s, clr_ovf_s, pop_s, push_s, drop_s;
  logic                 tx_in_unused;

  // Data and clear bits are quasi-static (held 3 clk before the toggle flips), so only the toggle is synchronised.
  assign tx_in_unused = ^jtag_tx_in[DR_LENGTH-3:8];

  // Host event decode, FIFO occupancy and overflow next-state, status word assembly.
  always_comb begin
    host_evt_s = (tx_tgl_sync_q != seen_tgl_q);
    clr_ovf_s  = jtag_tx_in[DR_LENGTH-2];
    pop_s      = (count_q != 4'd0) && cpu_rx_ready;
    push_s     = host_evt_s && !clr_ovf_s && ((count_q < 4'd8) || pop_s);
    drop_s     = host_evt_s && !clr_ovf_s && !push_s;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    if (host_evt_s && clr_ovf_s) begin
      overflow_d = 1'b0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    uart_state_d        = '0;
    uart_state_d[15:0]  = {(state_q == WAIT_ACK), seen_tgl_q, overflow_q,
                           count_q, host_tgl_q, host_byte_q};
  end

  // Synchronisers, host-event tracking, FIFO pointers/count, overflow and status register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_tgl_meta_q <= 1'b0;
      tx_tgl_sync_q <= 1'b0;
      ack_meta_q    <= 1'b0;
      ack_sync_q    <= 1'b0;
      seen_tgl_q    <= 1'b0;
      wptr_q        <= 3'd0;
      rptr_q        <= 3'd0;
      count_q       <= 4'd0;
      overflow_q    <= 1'b0;
      uart_state_q  <= '0;
    end else begin
      tx_tgl_meta_q <= jtag_tx_in[DR_LENGTH-1];
      tx_tgl_sync_q <= tx_tgl_meta_q;
      ack_meta_q    <= jtag_rx_ack;
      ack_sync_q    <= ack_meta_q;
      if (host_evt_s) seen_tgl_q <= tx_tgl_sync_q;
      if (push_s)     wptr_q     <= wptr_q + 3'd1;
      if (pop_s)      rptr_q     <= rptr_q + 3'd1;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      uart_state_q  <= uart_state_d;
    end
  end

  // FIFO storage is left unreset; it is only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wptr_q] <= jtag_tx_in[7:0];
  end

  // CPU-to-host handshake: latch a byte, flip host_tgl, wait for the host's ack toggle to match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      host_tgl_q  <= 1'b0;
      host_byte_q <= 8'h00;
      tx_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_tx_valid) begin
            host_byte_q <= cpu_tx_data;
            host_tgl_q  <= ~host_tgl_q;
            state_q     <= WAIT_ACK;
            tx_ready_q  <= 1'b0;
          end
        end
        WAIT_ACK: begin
          if (ack_sync_q == host_tgl_q) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rx_valid = (count_q != 4'd0);
  assign cpu_rx_data  = mem_q[rptr_q];
  assign cpu_tx_ready = tx_ready_q;
  assign overflow     = overflow_q;
  assign uart_state   = uart_state_q;

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Directed self-checking bench for jtag_uart_bridge.
module tb_jtag_uart_bridge;

  localparam int DRL = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [DRL-1:0] jtag_tx_in;
  logic           jtag_rx_ack;
  logic [DRL-1:0] uart_state;
  logic [7:0]     cpu_rx_data;
  logic           cpu_rx_valid;
  logic           cpu_rx_ready;
  logic [7:0]     cpu_tx_data;
  logic           cpu_tx_valid;
  logic           cpu_tx_ready;
  logic           overflow;

  int checks   = 0;
  int failures = 0;
  logic tgl    = 1'b0;

  jtag_uart_bridge #(.DR_LENGTH(DRL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .jtag_tx_in   (jtag_tx_in),
    .jtag_rx_ack  (jtag_rx_ack),
    .uart_state   (uart_state),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .cpu_rx_ready (cpu_rx_ready),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_tx_valid (cpu_tx_valid),
    .cpu_tx_ready (cpu_tx_ready),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present data, hold 3 clk, flip toggle, then wait until the push edge has passed.
  task automatic host_send(input logic [7:0] b, input logic clr);
    jtag_tx_in[DRL-2] = clr;
    jtag_tx_in[7:0]   = b;
    tick(3);
    tgl = ~tgl;
    jtag_tx_in[DRL-1] = tgl;
    tick(3);
  endtask

  initial begin
    int lat;
    logic [7:0] got;
    reset_n      = 1'b0;
    jtag_tx_in   = '0;
    jtag_rx_ack  = 1'b0;
    cpu_rx_ready = 1'b0;
    cpu_tx_data  = 8'h00;
    cpu_tx_valid = 1'b0;
    tick(2);
    check_eq("rst_state", uart_state, 32'h0);
    check_eq("rst_rxv", {31'd0, cpu_rx_valid}, 32'd0);
    check_eq("rst_txr", {31'd0, cpu_tx_ready}, 32'd1);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single byte, consumer ready
    cpu_rx_ready = 1'b1;
    jtag_tx_in[7:0] = 8'h41;
    tick(3);
    tgl = ~tgl;
    jtag_tx_in[DRL-1] = tgl;
    lat = 0;
    got = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (cpu_rx_valid) begin
        lat = i;
        got = cpu_rx_data;
        break;
      end
    end
    check_eq("single_lat_le4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    check_eq("single_data", {24'd0, got}, 32'h41);
    tick(1);
    check_eq("single_pulse", {31'd0, cpu_rx_valid}, 32'd0);
    tick(1);
    check_eq("single_seen", {31'd0, uart_state[14]}, 32'd1);
    check_eq("single_cnt", {28'd0, uart_state[12:9]}, 32'd0);

    // Fill to 8, ninth dropped, drain, clear overflow
    cpu_rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      host_send(8'(i), 1'b0);
      if (i == 7) check_eq("fill8_noovf", {31'd0, overflow}, 32'd0);
    end
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
    tick(1);
    check_eq("full_cnt", {28'd0, uart_state[12:9]}, 32'd8);
    check_eq("full_ovf_bit", {31'd0, uart_state[13]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_valid", {31'd0, cpu_rx_valid}, 32'd1);
      check_eq("drain_data", {24'd0, cpu_rx_data}, 32'(i));
      cpu_rx_ready = 1'b1;
      tick(1);
      cpu_rx_ready = 1'b0;
    end
    check_eq("drained_valid", {31'd0, cpu_rx_valid}, 32'd0);
    host_send(8'h00, 1'b1);
    check_eq("ovf_clr", {31'd0, overflow}, 32'd0);
    tick(1);
    check_eq("clr_cnt", {28'd0, uart_state[12:9]}, 32'd0);
    check_eq("clr_valid", {31'd0, cpu_rx_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) host_send(8'(8'h10 + i), 1'b0);
    jtag_tx_in[DRL-2] = 1'b0;
    jtag_tx_in[7:0]   = 8'h18;
    tick(3);
    tgl = ~tgl;
    jtag_tx_in[DRL-1] = tgl;
    tick(2);
    check_eq("pp_head", {24'd0, cpu_rx_data}, 32'h10);
    cpu_rx_ready = 1'b1;
    tick(1);
    cpu_rx_ready = 1'b0;
    check_eq("pp_ovf", {31'd0, overflow}, 32'd0);
    tick(1);
    check_eq("pp_cnt", {28'd0, uart_state[12:9]}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("pp_drain", {24'd0, cpu_rx_data}, 32'(8'h11 + i));
      cpu_rx_ready = 1'b1;
      tick(1);
      cpu_rx_ready = 1'b0;
    end
    check_eq("pp_empty", {31'd0, cpu_rx_valid}, 32'd0);

    // CPU-to-host handshake
    cpu_tx_data  = 8'h5A;
    cpu_tx_valid = 1'b1;
    tick(1);
    cpu_tx_valid = 1'b0;
    check_eq("tx_busy", {31'd0, cpu_tx_ready}, 32'd0);
    tick(1);
    check_eq("tx_byte", {24'd0, uart_state[7:0]}, 32'h5A);
    check_eq("tx_tgl", {31'd0, uart_state[8]}, 32'd1);
    check_eq("tx_wait", {31'd0, uart_state[15]}, 32'd1);
    cpu_tx_valid = 1'b1;
    tick(4);
    check_eq("tx_hold", {31'd0, cpu_tx_ready}, 32'd0);
    cpu_tx_valid = 1'b0;
    jtag_rx_ack = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (cpu_tx_ready) begin
        lat = i;
        break;
      end
    end
    check_eq("ack_lat_le3", {31'd0, (lat >= 1 && lat <= 3)}, 32'd1);
    check_eq("ack_ready", {31'd0, cpu_tx_ready}, 32'd1);

    // Reset mid-transfer
    for (int i = 0; i < 3; i++) host_send(8'(8'h60 + i), 1'b0);
    cpu_tx_data  = 8'hC3;
    cpu_tx_valid = 1'b1;
    tick(1);
    cpu_tx_valid = 1'b0;
    tick(1);
    check_eq("pre_rst_wait", {31'd0, uart_state[15]}, 32'd1);
    check_eq("pre_rst_cnt", {28'd0, uart_state[12:9]}, 32'd3);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_state", uart_state, 32'h0);
    check_eq("mid_rst_rxv", {31'd0, cpu_rx_valid}, 32'd0);
    check_eq("mid_rst_txr", {31'd0, cpu_tx_ready}, 32'd1);
    tgl = 1'b0;
    jtag_tx_in  = '0;
    jtag_rx_ack = 1'b0;
    tick(2);
    reset_n = 1'b1;
    cpu_rx_ready = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (cpu_rx_valid) lat++;
    end
    check_eq("post_rst_noemit", 32'(lat), 32'd0);

    // 20 bytes streamed with the FIFO kept drained
    for (int i = 0; i < 20; i++) begin
      host_send(8'(8'h80 + i), 1'b0);
      check_eq("stream_valid", {31'd0, cpu_rx_valid}, 32'd1);
      check_eq("stream_data", {24'd0, cpu_rx_data}, 32'(8'h80 + i));
    end
    tick(1);
    check_eq("stream_empty", {31'd0, cpu_rx_valid}, 32'd0);
    check_eq("stream_ovf", {31'd0, overflow}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
